// File: rtl/types_pkg.sv
// Shared types for the fetch front end: machine word, instruction-memory index,
// fetch FSM state and the {pc, instr} record carried by the fetch queue.
package types_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MEM_SIZE = 64;
  localparam int unsigned ADDR_W   = $clog2(MEM_SIZE);

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [ADDR_W-1:0] address_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  // Fetch is only legal for word-aligned addresses inside the instruction memory.
  function automatic logic pc_out_of_range(input word_t pc);
    return (pc >= word_t'(MEM_SIZE * 4)) || (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched {pc, instr}; entry 0 is always the head.
// Flush wins over push/pop; callers never pop empty or push full without a pop.
module fetch_fifo
  import types_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t [1:0] ent_q, ent_d;
  logic [1:0]         count_q, count_d;
  logic [1:0]         slot;

  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    slot    = count_q - {1'b0, pop_i};
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (pop_i) ent_d[0] = ent_q[1];
      // Write slot accounts for the shift caused by a simultaneous pop.
      if (push_i) ent_d[slot[0]] = push_data_i;
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = ent_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, RUN/FAULT control and a 2-deep output queue
// toward decode. Memory storage lives outside; imem_instruction is combinational.
module fetch_unit
  import types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     redirect_valid,
  input  word_t    redirect_pc,
  output address_t imem_address,
  input  word_t    imem_instruction,
  output logic     out_valid,
  input  logic     out_ready,
  output word_t    out_instr,
  output word_t    out_pc,
  output logic     fetch_fault
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  logic         pc_bad;
  logic         fetch_en;
  logic         fault_st;
  logic         push, pop, flush;
  logic [1:0]   fifo_count;
  logic         fifo_valid;
  fetch_entry_t fifo_head;
  fetch_entry_t fifo_wdata;

  assign pc_bad       = pc_out_of_range(pc_q);
  assign imem_address = pc_q[ADDR_W+1:2];
  assign fifo_valid   = (fifo_count != 2'd0);

  // A redirect squashes everything else happening in the same cycle.
  assign flush = redirect_valid;
  assign pop   = fifo_valid && out_ready && !redirect_valid;
  assign push  = fetch_en && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN:     if (pc_bad) state_d = FAULT;
        FAULT:   state_d = FAULT;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    fetch_en = 1'b0;
    fault_st = 1'b0;
    unique case (state_q)
      RUN:     fetch_en = !pc_bad && ((fifo_count != 2'd2) || pop);
      FAULT:   fault_st = 1'b1;
      default: fetch_en = 1'b0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (push)      pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign fifo_wdata.pc    = pc_q;
  assign fifo_wdata.instr = imem_instruction;

  fetch_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (flush),
    .push_data_i (fifo_wdata),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  // Outputs are forced quiet for the whole reset cycle, not just after the edge.
  assign out_valid   = !rst && fifo_valid;
  assign out_instr   = rst ? '0 : fifo_head.instr;
  assign out_pc      = rst ? '0 : fifo_head.pc;
  assign fetch_fault = !rst && fault_st;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational memory model holding i*16.
module tb_fetch_unit;
  import types_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     redirect_valid;
  word_t    redirect_pc;
  address_t imem_address;
  word_t    imem_instruction;
  logic     out_valid;
  logic     out_ready;
  word_t    out_instr;
  word_t    out_pc;
  logic     fetch_fault;

  word_t mem [MEM_SIZE];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_instruction = mem[imem_address];

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .fetch_fault      (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = word_t'(i * 16);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    step();
    step();

    // reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc",    out_pc,    0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_addr",  imem_address, 0);

    // streaming after reset release
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stream_v%0d", i), out_valid, 1);
      chk($sformatf("stream_pc%0d", i), out_pc, 32'(i * 4));
      chk($sformatf("stream_in%0d", i), out_instr, 32'(i * 16));
    end

    // back-pressure fills the queue and holds everything
    rst = 1'b1; out_ready = 1'b0;
    step();
    chk("bp_rst_valid", out_valid, 0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("bp_v%0d", k), out_valid, 1);
      chk($sformatf("bp_pc%0d", k), out_pc, 0);
    end
    chk("bp_addr",  imem_address, 2);
    chk("bp_instr", out_instr, 0);
    out_ready = 1'b1;
    chk("bp_rel0", out_pc, 0);
    step(); chk("bp_rel4", out_pc, 4);  chk("bp_rel4i", out_instr, 16);
    step(); chk("bp_rel8", out_pc, 8);  chk("bp_rel8i", out_instr, 32);
    step(); chk("bp_rel12", out_pc, 12); chk("bp_rel12i", out_instr, 48);

    // redirect while full drops the queued entries
    out_ready = 1'b0;
    step();
    chk("rd_full_v", out_valid, 1);
    chk("rd_full_pc", out_pc, 12);
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("rd_bubble", out_valid, 0);
    step();
    chk("rd_v", out_valid, 1);
    chk("rd_pc", out_pc, 32'h40);
    chk("rd_in", out_instr, 32'h100);
    step();
    chk("rd_pc2", out_pc, 32'h44);
    chk("rd_in2", out_instr, 32'h110);

    // misaligned redirect faults; a good redirect recovers
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("mis_v0", out_valid, 0);
    step();
    chk("mis_fault", fetch_fault, 1);
    chk("mis_v1", out_valid, 0);
    step();
    chk("mis_fault2", fetch_fault, 1);
    chk("mis_v2", out_valid, 0);
    chk("mis_addr", imem_address, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("rec_fault", fetch_fault, 0);
    chk("rec_v0", out_valid, 0);
    step();
    chk("rec_v", out_valid, 1);
    chk("rec_pc", out_pc, 32'h10);
    chk("rec_in", out_instr, 32'h40);

    // running off the end of memory
    redirect_valid = 1'b1; redirect_pc = word_t'(MEM_SIZE * 4 - 8);
    step();
    redirect_valid = 1'b0;
    step();
    chk("end_pc0", out_pc, word_t'(MEM_SIZE * 4 - 8));
    step();
    chk("end_v1", out_valid, 1);
    chk("end_pc1", out_pc, word_t'(MEM_SIZE * 4 - 4));
    chk("end_in1", out_instr, word_t'((MEM_SIZE - 1) * 16));
    chk("end_nf", fetch_fault, 0);
    step();
    chk("end_fault", fetch_fault, 1);
    chk("end_v2", out_valid, 0);

    // reset beats a simultaneous redirect mid-stream
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    step();
    step();
    chk("rr_full_v", out_valid, 1);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    #1;
    chk("rr_during_v", out_valid, 0);
    step();
    chk("rr_v", out_valid, 0);
    chk("rr_addr", imem_address, 0);
    chk("rr_fault", fetch_fault, 0);
    rst = 1'b0; redirect_valid = 1'b0;
    step();
    chk("rr_post_v", out_valid, 1);
    chk("rr_post_pc", out_pc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
